bitwise_logic_accum: RTL and testbench

BITWISE_LOGIC_ACCUM -- requirements
Module: bitwise_logic_accum

---
 rtl/bitwise_logic_accum.sv | 178 +++++++++++++++++
 tb/tb_bitwise_logic_accum.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_accum.sv
// bitwise_logic_accum: applies a bitwise op to each accepted (a, b) beat and
// folds the per-beat results of a burst into one result. A burst closes on
// in_last or when MAX_BEATS beats have been folded. The closed result is held
// in a single-entry output register behind a valid/ready handshake.

module bitwise_logic_accum #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_a,
    input  logic [WIDTH-1:0]                   in_b,
    input  logic [1:0]                         in_op,
    input  logic                               in_last,

    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [$clog2(MAX_BEATS+1)-1:0]     out_count,
    output logic                               out_trunc
);

    localparam int unsigned CW = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Burst context: op latched on the first beat, running fold, beats so far
    logic [1:0]       op_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;

    // Per-beat datapath
    logic             accept_c;
    logic             first_c;
    logic [1:0]       op_eff_c;
    logic [WIDTH-1:0] beat_r_c;
    logic [WIDTH-1:0] acc_nxt_c;
    logic [CW-1:0]    cnt_nxt_c;
    logic             final_c;

    // FSM outputs
    logic             emit_c;
    logic             trunc_c;
    logic             open_c;

    // The held result blocks new beats only when it cannot drain this edge;
    // nothing is accepted while reset is asserted.
    assign in_ready = !rst && !(out_valid && !out_ready);

    assign accept_c = in_valid && in_ready;

    // Per-beat op selection, bitwise result and fold into the running value
    always_comb begin
        first_c   = (state == IDLE);
        op_eff_c  = first_c ? in_op : op_q;
        beat_r_c  = '0;
        acc_nxt_c = '0;

        case (op_eff_c)
            OP_AND:  beat_r_c = in_a & in_b;
            OP_OR:   beat_r_c = in_a | in_b;
            OP_XOR:  beat_r_c = in_a ^ in_b;
            OP_XNOR: beat_r_c = ~(in_a ^ in_b);
            default: beat_r_c = '0;
        endcase

        if (first_c) begin
            acc_nxt_c = beat_r_c;
        end else begin
            case (op_eff_c)
                OP_AND,
                OP_XNOR: acc_nxt_c = acc_q & beat_r_c;
                OP_OR:   acc_nxt_c = acc_q | beat_r_c;
                OP_XOR:  acc_nxt_c = acc_q ^ beat_r_c;
                default: acc_nxt_c = '0;
            endcase
        end

        // cnt_q never exceeds MAX_BEATS-1 while a burst is open, so no wrap
        cnt_nxt_c = first_c ? CW'(1) : (cnt_q + CW'(1));
        final_c   = in_last || (cnt_nxt_c == CW'(MAX_BEATS));
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: open on a non-final beat, close on a final beat
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c && !final_c) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (accept_c && final_c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: emit strobe, truncation flag, burst-open strobe
    always_comb begin
        emit_c  = 1'b0;
        trunc_c = 1'b0;
        open_c  = 1'b0;
        case (state)
            IDLE: begin
                emit_c = accept_c && final_c;
                open_c = accept_c && !final_c;
            end
            ACC: begin
                emit_c = accept_c && final_c;
            end
            default: begin
                emit_c = 1'b0;
            end
        endcase
        trunc_c = emit_c && !in_last;
    end

    // Burst context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= OP_AND;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept_c) begin
            acc_q <= acc_nxt_c;
            cnt_q <= final_c ? '0 : cnt_nxt_c;
            if (open_c) begin
                op_q <= in_op;
            end
        end
    end

    // Output holding register: load on emit, otherwise drain on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_trunc <= 1'b0;
        end else if (emit_c) begin
            out_valid <= 1'b1;
            out_data  <= acc_nxt_c;
            out_count <= cnt_nxt_c;
            out_trunc <= trunc_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bitwise_logic_accum.sv
// Bench for bitwise_logic_accum (WIDTH=8, MAX_BEATS=4): directed table,
// hand-written multi-cycle sequences, then random traffic against a
// burst-level reference model.

module tb_bitwise_logic_accum;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_BEATS = 4;
    localparam int unsigned CW        = $clog2(MAX_BEATS + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             out_trunc;

    int checks;
    int errors;

    bitwise_logic_accum #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, cross the rising edge, settle just after it
    task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic last, input logic ordy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_last   = last;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, ordy);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_trunc", 64'(out_trunc), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic chk_out(input string name, input logic [7:0] d, input int cnt, input logic tr);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"}, 64'(out_data), 64'(d));
        chk({name, "_count"}, 64'(out_count), 64'(cnt));
        chk({name, "_trunc"}, 64'(out_trunc), 64'(tr));
    endtask

    // Reference model: the per-beat op, and a burst folded from its beat list
    function automatic logic [7:0] beat_r(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic logic [7:0] fold(input logic [1:0] op, input logic [7:0] rs[$]);
        logic [7:0] r;
        r = rs[0];
        for (int i = 1; i < rs.size(); i++) begin
            if (op == 2'b01)      r = r | rs[i];
            else if (op == 2'b10) r = r ^ rs[i];
            else                  r = r & rs[i];
        end
        return r;
    endfunction

    initial begin
        logic [7:0] held_d;
        logic [7:0] rq[$];
        logic [1:0] bop;
        logic [7:0] ra, rb, ed, pd;
        logic [1:0] rop;
        logic       rv, rl, ro, acc_b, held, emit, et, pt;
        int         ec;
        logic [CW-1:0] pc;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_last = 1'b0; out_ready = 1'b0;

        vecs[0] = '{op: 2'b01, a: 8'h0F, b: 8'hF0, exp_data: 8'hFF};
        vecs[1] = '{op: 2'b00, a: 8'hCC, b: 8'hAA, exp_data: 8'h88};
        vecs[2] = '{op: 2'b01, a: 8'hCC, b: 8'hAA, exp_data: 8'hEE};
        vecs[3] = '{op: 2'b10, a: 8'hCC, b: 8'hAA, exp_data: 8'h66};
        vecs[4] = '{op: 2'b11, a: 8'hCC, b: 8'hAA, exp_data: 8'h99};

        do_reset();

        // Single-beat bursts from the table
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, 1'b1);
            chk_out($sformatf("single%0d", i), vecs[i].exp_data, 1, 1'b0);
            idle(1'b1);
            chk("single_drain", 64'(out_valid), 64'd0);
        end

        // AND burst; op change on beat 2 must be ignored
        cyc(1'b1, 8'hFF, 8'hF0, 2'b00, 1'b0, 1'b1);
        chk("and_b1_no_out", 64'(out_valid), 64'd0);
        cyc(1'b1, 8'h3C, 8'hFF, 2'b01, 1'b0, 1'b1);
        cyc(1'b1, 8'hFF, 8'h30, 2'b01, 1'b1, 1'b1);
        chk_out("and_burst", 8'h30, 3, 1'b0);
        idle(1'b1);

        // Truncation at MAX_BEATS, then a fresh burst
        cyc(1'b1, 8'h01, 8'h00, 2'b01, 1'b0, 1'b1);
        cyc(1'b1, 8'h02, 8'h00, 2'b01, 1'b0, 1'b1);
        cyc(1'b1, 8'h04, 8'h00, 2'b01, 1'b0, 1'b1);
        chk("trunc_b3_no_out", 64'(out_valid), 64'd0);
        cyc(1'b1, 8'h08, 8'h00, 2'b01, 1'b0, 1'b1);
        chk_out("trunc", 8'h0F, 4, 1'b1);
        cyc(1'b1, 8'h10, 8'h00, 2'b01, 1'b1, 1'b1);
        chk_out("after_trunc", 8'h10, 1, 1'b0);
        idle(1'b1);

        // Full MAX_BEATS burst ending with in_last reports no truncation
        cyc(1'b1, 8'h11, 8'h00, 2'b10, 1'b0, 1'b1);
        cyc(1'b1, 8'h22, 8'h00, 2'b10, 1'b0, 1'b1);
        cyc(1'b1, 8'h44, 8'h00, 2'b10, 1'b0, 1'b1);
        cyc(1'b1, 8'h88, 8'h00, 2'b10, 1'b1, 1'b1);
        chk_out("full_last", 8'hFF, 4, 1'b0);
        idle(1'b1);

        // Backpressure hold, then simultaneous drain and load
        cyc(1'b1, 8'hF0, 8'h0F, 2'b10, 1'b1, 1'b0);
        chk_out("hold_load", 8'hFF, 1, 1'b0);
        held_d = out_data;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_op = 2'b00; in_last = 1'b1; out_ready = 1'b0;
            #1;
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            cyc(1'b1, 8'hAA, 8'h55, 2'b00, 1'b1, 1'b0);
            chk("hold_data", 64'(out_data), 64'(held_d));
            chk("hold_valid", 64'(out_valid), 64'd1);
        end
        cyc(1'b1, 8'hAA, 8'h0F, 2'b00, 1'b1, 1'b1);
        chk_out("no_bubble", 8'h0A, 1, 1'b0);
        idle(1'b1);

        // Reset mid-burst discards the partial burst
        cyc(1'b1, 8'h01, 8'h00, 2'b01, 1'b0, 1'b1);
        cyc(1'b1, 8'h02, 8'h00, 2'b01, 1'b0, 1'b1);
        do_reset();
        idle(1'b1);
        chk("mid_rst_no_out", 64'(out_valid), 64'd0);
        cyc(1'b1, 8'h55, 8'h0F, 2'b10, 1'b1, 1'b1);
        chk_out("post_rst_xor", 8'h5A, 1, 1'b0);
        idle(1'b1);

        // Random traffic against the burst-level model
        do_reset();
        rq.delete();
        bop = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            rv  = ($urandom_range(0, 3) != 0);
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 2'($urandom);
            rl  = ($urandom_range(0, 3) == 0);
            ro  = ($urandom_range(0, 2) != 0);
            in_valid = rv; in_a = ra; in_b = rb; in_op = rop; in_last = rl; out_ready = ro;
            #1;
            chk("rnd_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            acc_b = rv && in_ready;
            held  = out_valid && !ro;
            pd = out_data; pc = out_count; pt = out_trunc;
            emit = 1'b0; ed = '0; ec = 0; et = 1'b0;
            if (acc_b) begin
                if (rq.size() == 0) bop = rop;
                rq.push_back(beat_r(bop, ra, rb));
                if (rl || rq.size() == MAX_BEATS) begin
                    emit = 1'b1;
                    ed   = fold(bop, rq);
                    ec   = rq.size();
                    et   = !rl;
                    rq.delete();
                end
            end
            @(posedge clk);
            #1;
            if (emit) begin
                chk_out("rnd_emit", ed, ec, et);
            end else if (held) begin
                chk("rnd_hold_valid", 64'(out_valid), 64'd1);
                chk("rnd_hold_data", 64'(out_data), 64'(pd));
                chk("rnd_hold_count", 64'(out_count), 64'(pc));
                chk("rnd_hold_trunc", 64'(out_trunc), 64'(pt));
            end else begin
                chk("rnd_idle_valid", 64'(out_valid), 64'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
